mc_unit_sched: RTL



---
 rtl/mc_unit_sched.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_unit_sched.sv
// -----------------------------------------------------------------------------
// mc_unit_sched
//
// Issue/stall scheduler for the multicycle execute resources (integer MUL,
// integer DIV, FADD/FSUB, FSQRT). One multicycle op is tracked at a time. The
// execute stage is stalled through busy for the unit's latency. The selected
// unit output is then captured and presented to writeback, with its
// destination register, for one cycle. Single-cycle ops (unit code 0 or 5-7)
// pass through without touching the scheduler.
//
// Ports
//   clk          clock
//   rstn         asynchronous active-low reset
//   issue_valid  execute stage issuing this cycle
//   issue_unit   0=none, 1=MUL, 2=DIV, 3=FADD/FSUB, 4=FSQRT, 5-7=none
//   issue_rd     destination register of the issued op
//   flush        abort the in-flight op (branch redirect)
//   mul_out      MUL result
//   div_quot     DIV quotient
//   div_valid    DIV output-valid strobe
//   fadd_out     FADD/FSUB result
//   fsqrt_out    FSQRT result
//   busy         pipeline stall request (combinational)
//   res_valid    one-cycle result strobe
//   res_data     captured result, held until the next capture
//   res_rd       destination register of res_data
//   active_unit  unit code in flight, 0 when idle
//   err_timeout  sticky DIV watchdog abort flag
// -----------------------------------------------------------------------------
module mc_unit_sched #(
  parameter int MUL_LAT       = 2,
  parameter int DIV_LAT       = 36,
  parameter int FADD_LAT      = 3,
  parameter int FSQRT_LAT     = 4,
  parameter int DIV_USE_VALID = 1,
  parameter int TIMEOUT       = 255,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  input  logic [2:0]  issue_unit,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  input  logic [31:0] mul_out,
  input  logic [31:0] div_quot,
  input  logic        div_valid,
  input  logic [31:0] fadd_out,
  input  logic [31:0] fsqrt_out,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic [2:0]  active_unit,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] UNIT_MUL   = 3'd1;
  localparam logic [2:0] UNIT_DIV   = 3'd2;
  localparam logic [2:0] UNIT_FADD  = 3'd3;
  localparam logic [2:0] UNIT_FSQRT = 3'd4;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [2:0]       unit_reg;
  logic [4:0]       rd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] wd_reg;
  logic [31:0]      res_data_reg;
  logic [4:0]       res_rd_reg;
  logic             err_reg;

  logic             unit_ok;
  logic             accept;
  logic [CNT_W-1:0] lat_sel;
  logic [31:0]      unit_result;
  logic             need_valid;
  logic             cnt_done;
  logic             op_ready;
  logic             wd_expire;

  // Only codes 1..4 name a multicycle resource.
  assign unit_ok = (issue_unit >= UNIT_MUL) && (issue_unit <= UNIT_FSQRT);

  // rstn is folded in so busy reads 0 while reset is held, even if the
  // execute stage happens to present an issue during reset.
  assign accept = rstn && issue_valid && unit_ok && !flush &&
                  ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    lat_sel = '0;
    case (issue_unit)
      UNIT_MUL:   lat_sel = CNT_W'(MUL_LAT);
      UNIT_DIV:   lat_sel = CNT_W'(DIV_LAT);
      UNIT_FADD:  lat_sel = CNT_W'(FADD_LAT);
      UNIT_FSQRT: lat_sel = CNT_W'(FSQRT_LAT);
      default:    lat_sel = '0;
    endcase
  end

  always_comb begin
    unit_result = '0;
    case (unit_reg)
      UNIT_MUL:   unit_result = mul_out;
      UNIT_DIV:   unit_result = div_quot;
      UNIT_FADD:  unit_result = fadd_out;
      UNIT_FSQRT: unit_result = fsqrt_out;
      default:    unit_result = '0;
    endcase
  end

  assign need_valid = (unit_reg == UNIT_DIV) && (DIV_USE_VALID != 0);

  // cnt==1 is the nominal completion cycle; cnt==0 means the op is overdue
  // (only possible for a DIV still waiting for div_valid).
  assign cnt_done = (cnt_reg <= CNT_W'(1));
  assign op_ready = cnt_done && (!need_valid || div_valid);

  // The watchdog counts overdue cycles without div_valid; the cycle that
  // would bring it to TIMEOUT is the abort cycle.
  assign wd_expire = need_valid && (cnt_reg == '0) && !div_valid &&
                     (wd_reg >= WD_LAST);

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_next = IDLE;
        end else if (op_ready || wd_expire) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Back-to-back issue skips the idle bubble.
        state_next = accept ? WAIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: op latch, latency counter, watchdog, result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      unit_reg     <= '0;
      rd_reg       <= '0;
      cnt_reg      <= '0;
      wd_reg       <= '0;
      res_data_reg <= '0;
      res_rd_reg   <= '0;
      err_reg      <= 1'b0;
    end else if (accept) begin
      unit_reg <= issue_unit;
      rd_reg   <= issue_rd;
      cnt_reg  <= lat_sel;
      wd_reg   <= '0;
    end else if ((state_reg == WAIT) && !flush) begin
      if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (need_valid && (cnt_reg == '0) && !div_valid) begin
        wd_reg <= wd_reg + CNT_W'(1);
      end
      // A real div_valid wins over the abort in the same cycle.
      if (op_ready) begin
        res_data_reg <= unit_result;
        res_rd_reg   <= rd_reg;
      end else if (wd_expire) begin
        res_data_reg <= '0;
        res_rd_reg   <= rd_reg;
        err_reg      <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy        = accept || (state_reg == WAIT);
  assign res_valid   = (state_reg == DONE);
  assign res_data    = res_data_reg;
  assign res_rd      = res_rd_reg;
  assign active_unit = (state_reg == IDLE) ? 3'd0 : unit_reg;
  assign err_timeout = err_reg;

endmodule
